// File: rtl/bridge_pkg.sv
// Shared definitions for the cache-to-AXI bridge: FSM encodings, AXI
// constants and the request-type decode used by both read and write paths.
package bridge_pkg;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_AR   = 3'b010,
    R_DATA = 3'b100
  } rd_state_t;

  typedef enum logic [3:0] {
    W_IDLE = 4'b0001,
    W_AW   = 4'b0010,
    W_DATA = 4'b0100,
    W_RESP = 4'b1000
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] TYPE_LINE      = 3'd4;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
  } xfer_shape_t;

  // Line requests become a 4-beat word burst; anything else is a single
  // beat whose size is the low two bits of the type.
  function automatic xfer_shape_t decode_type(input logic [2:0] typ);
    xfer_shape_t s;
    if (typ == TYPE_LINE) begin
      s.len  = 8'd3;
      s.size = 3'd2;
    end else begin
      s.len  = '0;
      s.size = {1'b0, typ[1:0]};
    end
    return s;
  endfunction

endpackage

// File: rtl/bridge_wr_ch.sv
// AXI write channel of the bridge: AW/W/B sequencing with a captured line
// buffer and a beat counter selecting the outgoing word.
module bridge_wr_ch
  import bridge_pkg::*;
#(
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         idle,
  output logic [31:0]  buf_addr,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  wr_state_t   state, state_nx;
  logic [31:0]  addr_q;
  logic [7:0]   len_q;
  logic [2:0]   size_q;
  logic [3:0]   strb_q;
  logic [127:0] data_q;
  logic [1:0]   beat;
  logic         accept;
  xfer_shape_t  shape;

  assign shape  = decode_type(wr_type);
  assign accept = wr_req && (state == W_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= W_IDLE;
    else         state <= state_nx;
  end

  // Capture the request so the cache may change its inputs after accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      strb_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      addr_q <= wr_addr;
      len_q  <= shape.len;
      size_q <= shape.size;
      strb_q <= (wr_type == TYPE_LINE) ? 4'hF : wr_wstrb;
      data_q <= wr_data;
    end
  end

  // Beat counter selects the word on W; restarts with each new request.
  always_ff @(posedge clk) begin
    if (!resetn)                          beat <= '0;
    else if (accept)                      beat <= '0;
    else if (state == W_DATA && wready)   beat <= beat + 2'd1;
  end

  // Next-state and channel handshake outputs.
  always_comb begin
    state_nx = state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    case (state)
      W_IDLE: if (wr_req) state_nx = W_AW;
      W_AW: begin
        awvalid = 1'b1;
        if (awready) state_nx = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) state_nx = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nx = W_IDLE;
      end
      default: state_nx = W_IDLE;
    endcase
  end

  assign wr_rdy   = (state == W_IDLE);
  assign idle     = (state == W_IDLE);
  assign buf_addr = addr_q;
  assign awid     = WR_ID;
  assign awaddr   = addr_q;
  assign awlen    = len_q;
  assign awsize   = size_q;
  assign wid      = WR_ID;
  assign wdata    = data_q[{beat, 5'b00000} +: 32];
  assign wstrb    = strb_q;
  assign wlast    = ({6'b0, beat} == len_q);

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache refill/write-back interface to AXI4 master. Read path lives here;
// the write path is in bridge_wr_ch. Reads to a line still being written
// back are held off so a refill never sees stale memory.
module cache_axi_bridge
  import bridge_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  rd_state_t   rd_state, rd_next;
  logic [31:0] rd_addr_q;
  logic [7:0]  rd_len_q;
  logic [2:0]  rd_size_q;
  xfer_shape_t rd_shape;
  logic        rd_accept;
  logic        wr_idle;
  logic [31:0] wr_buf_addr;
  logic        hazard;
  logic        unused_inputs;

  assign unused_inputs = ^{rid, rresp, bid, bresp};

  assign rd_shape  = decode_type(rd_type);
  // A read may not overtake a write-back to the same line, including one
  // being accepted in this very cycle.
  assign hazard = (!wr_idle && (rd_addr[31:4] == wr_buf_addr[31:4])) ||
                  (wr_req && wr_rdy && (rd_addr[31:4] == wr_addr[31:4]));
  assign rd_rdy    = (rd_state == R_IDLE) && !hazard;
  assign rd_accept = rd_req && rd_rdy;

  // Read state register.
  always_ff @(posedge clk) begin
    if (!resetn) rd_state <= R_IDLE;
    else         rd_state <= rd_next;
  end

  // Capture the read request payload on accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      rd_size_q <= '0;
    end else if (rd_accept) begin
      rd_addr_q <= rd_addr;
      rd_len_q  <= rd_shape.len;
      rd_size_q <= rd_shape.size;
    end
  end

  // Read next-state and AR/R handshake outputs; returned data passes straight through.
  always_comb begin
    rd_next   = rd_state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    case (rd_state)
      R_IDLE: if (rd_accept) rd_next = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_next = R_DATA;
      end
      R_DATA: begin
        rready    = 1'b1;
        ret_valid = rvalid;
        ret_last  = rlast;
        if (rvalid && rlast) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  assign ret_data = rdata;
  assign arid     = RD_ID;
  assign araddr   = rd_addr_q;
  assign arlen    = rd_len_q;
  assign arsize   = rd_size_q;
  assign arburst  = AXI_BURST_INCR;
  assign arlock   = '0;
  assign arcache  = '0;
  assign arprot   = '0;
  assign awburst  = AXI_BURST_INCR;
  assign awlock   = '0;
  assign awcache  = '0;
  assign awprot   = '0;

  bridge_wr_ch #(.WR_ID(WR_ID)) u_wr_ch (
    .clk      (clk),
    .resetn   (resetn),
    .wr_req   (wr_req),
    .wr_type  (wr_type),
    .wr_addr  (wr_addr),
    .wr_wstrb (wr_wstrb),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .idle     (wr_idle),
    .buf_addr (wr_buf_addr),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awvalid  (awvalid),
    .awready  (awready),
    .wid      (wid),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .bready   (bready)
  );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: table of read/write requests
// plus hand-written hazard, back-pressure and reset sequences.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [1:0]   arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [1:0]   awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  always #5 clk = ~clk;

  cache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   strb;
    logic [127:0] data;
    logic [7:0]   exp_len;
    logic [2:0]   exp_size;
    logic [3:0]   exp_strb;
    int unsigned  stall;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  vec_t  vecs [5];
  beat_t sb [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wbeats(input logic [127:0] data, input logic [7:0] len, input logic [3:0] strb);
    for (int i = 0; i <= int'(len); i++)
      sb.push_back('{data: data[i*32 +: 32], strb: strb, last: (i == int'(len))});
  endtask

  // Drain the expected W beats (with optional initial and mid-burst wready
  // stalls), then complete the B handshake.
  task automatic w_data_phase(input int unsigned stall, input logic hazard_chk);
    int unsigned k = 0;
    while (sb.size() != 0 && k < 60) begin
      wready = (k >= stall) && !(stall != 0 && k == stall + 2);
      #1;
      if (hazard_chk) chk("hazard_rd_rdy_wdata", rd_rdy, 0);
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, sb[0].data);
      chk("wstrb", wstrb, sb[0].strb);
      chk("wlast", wlast, sb[0].last);
      if (wready) void'(sb.pop_front());
      cyc();
      k++;
    end
    wready = 1'b0;
    if (sb.size() != 0) begin
      chk("w_beats_timeout", sb.size(), 0);
      sb.delete();
    end
    #1;
    chk("wvalid_after_last", wvalid, 0);
    chk("bready", bready, 1);
    chk("wr_rdy_resp", wr_rdy, 0);
    if (hazard_chk) chk("hazard_rd_rdy_resp", rd_rdy, 0);
    cyc();
    chk("bready_hold", bready, 1);
    chk("wr_rdy_resp_hold", wr_rdy, 0);
    bvalid = 1'b1;
    #1;
    chk("wr_rdy_during_b", wr_rdy, 0);
    if (hazard_chk) chk("hazard_rd_rdy_b", rd_rdy, 0);
    cyc();
    bvalid = 1'b0;
    #1;
    chk("wr_rdy_after_b", wr_rdy, 1);
    chk("bready_after_b", bready, 0);
  endtask

  task automatic do_write(input vec_t v);
    wr_req = 1'b1; wr_type = v.typ; wr_addr = v.addr; wr_wstrb = v.strb; wr_data = v.data;
    #1;
    chk("wr_rdy_idle", wr_rdy, 1);
    cyc();
    wr_req = 1'b0; wr_type = 3'd0; wr_addr = '1; wr_wstrb = 4'h0; wr_data = ~v.data;
    #1;
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, v.addr);
    chk("awlen", awlen, v.exp_len);
    chk("awsize", awsize, v.exp_size);
    chk("awid", awid, 4'd1);
    chk("wvalid_in_aw", wvalid, 0);
    chk("wr_rdy_busy", wr_rdy, 0);
    for (int unsigned i = 0; i < v.stall; i++) begin
      cyc();
      chk("awvalid_hold", awvalid, 1);
      chk("awaddr_hold", awaddr, v.addr);
      chk("awlen_hold", awlen, v.exp_len);
    end
    awready = 1'b1;
    cyc();
    awready = 1'b0;
    push_wbeats(v.data, v.exp_len, v.exp_strb);
    w_data_phase(v.stall, 1'b0);
  endtask

  task automatic do_read(input vec_t v, input logic [31:0] base);
    rd_req = 1'b1; rd_type = v.typ; rd_addr = v.addr;
    #1;
    chk("rd_rdy_idle", rd_rdy, 1);
    cyc();
    rd_req = 1'b0; rd_type = 3'd0; rd_addr = '1;
    #1;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, v.addr);
    chk("arlen", arlen, v.exp_len);
    chk("arsize", arsize, v.exp_size);
    chk("arid", arid, 4'd0);
    chk("rready_in_ar", rready, 0);
    for (int unsigned i = 0; i < v.stall; i++) begin
      cyc();
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, v.addr);
      chk("arlen_hold", arlen, v.exp_len);
    end
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    #1;
    chk("rready", rready, 1);
    chk("ret_valid_idle", ret_valid, 0);
    for (int i = 0; i <= int'(v.exp_len); i++) begin
      if (i == 1) begin
        rvalid = 1'b0;
        #1;
        chk("ret_valid_gap", ret_valid, 0);
        cyc();
      end
      rvalid = 1'b1; rdata = base + 32'(i); rlast = (i == int'(v.exp_len));
      sb.push_back('{data: base + 32'(i), strb: 4'h0, last: (i == int'(v.exp_len))});
      #1;
      if (ret_valid) begin
        chk("ret_data", ret_data, sb[0].data);
        chk("ret_last", ret_last, sb[0].last);
        void'(sb.pop_front());
      end else begin
        chk("ret_valid", ret_valid, 1);
      end
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("rd_rdy_after_rlast", rd_rdy, 1);
    chk("rready_after_rlast", rready, 0);
    chk("ret_valid_after_rlast", ret_valid, 0);
    if (sb.size() != 0) begin
      chk("r_beats_left", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    resetn = 1'b0;
    rd_req = 1'b0; rd_type = 3'd0; rd_addr = '0;
    wr_req = 1'b0; wr_type = 3'd0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; rid = 4'd0; rdata = '0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;

    vecs[0] = '{3'd4, 32'h1C00_0080, 4'h0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 8'd3, 3'd2, 4'hF, 0};
    vecs[1] = '{3'd2, 32'h1C00_0100, 4'b0011, {96'h0, 32'h1234_5678}, 8'd0, 3'd2, 4'b0011, 0};
    vecs[2] = '{3'd0, 32'h0000_0003, 4'b1000, {96'h0, 32'hAB00_0000}, 8'd0, 3'd0, 4'b1000, 1};
    vecs[3] = '{3'd1, 32'h0000_0A02, 4'b1100, {96'h0, 32'hBEEF_0000}, 8'd0, 3'd1, 4'b1100, 2};
    vecs[4] = '{3'd4, 32'h1C00_0040, 4'b0101,
                {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 8'd3, 3'd2, 4'hF, 5};

    cyc(); cyc();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_last", ret_last, 0);
    chk("rst_rd_rdy", rd_rdy, 1);
    chk("rst_wr_rdy", wr_rdy, 1);
    chk("arburst", arburst, 2'b01);
    chk("awburst", awburst, 2'b01);
    chk("tieoffs", {arlock, awlock, arcache, awcache, arprot, awprot}, 0);
    resetn = 1'b1;
    cyc();

    // Table: each request shape as a write then a read.
    for (int i = 0; i < 5; i++) begin
      do_write(vecs[i]);
      do_read(vecs[i], 32'hA0 + 32'(i << 8));
    end

    // Hazard: write-back to line 0x1C000080 blocks reads to that line.
    wr_req = 1'b1; wr_type = 3'd4; wr_addr = 32'h1C00_0080; wr_wstrb = 4'h0;
    wr_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    rd_req = 1'b1; rd_type = 3'd2; rd_addr = 32'h1C00_0084;
    #1;
    chk("hz_wr_rdy", wr_rdy, 1);
    chk("hz_same_cycle", rd_rdy, 0);
    cyc();
    wr_req = 1'b0;
    #1;
    chk("hz_in_aw", rd_rdy, 0);
    chk("hz_no_ar", arvalid, 0);
    rd_addr = 32'h1C00_00C0;
    #1;
    chk("hz_other_line", rd_rdy, 1);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("hz_arvalid", arvalid, 1);
    chk("hz_araddr", araddr, 32'h1C00_00C0);
    chk("hz_awvalid", awvalid, 1);
    chk("hz_awaddr", awaddr, 32'h1C00_0080);
    arready = 1'b1; awready = 1'b1;
    cyc();
    arready = 1'b0; awready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5A5A_0001;
    #1;
    chk("hz_ret_valid", ret_valid, 1);
    chk("hz_ret_data", ret_data, 32'h5A5A_0001);
    chk("hz_ret_last", ret_last, 1);
    chk("hz_wvalid_concurrent", wvalid, 1);
    cyc();
    rvalid = 1'b0; rlast = 1'b0;
    rd_req = 1'b1; rd_type = 3'd2; rd_addr = 32'h1C00_0084;
    push_wbeats({32'hC3, 32'hC2, 32'hC1, 32'hC0}, 8'd3, 4'hF);
    w_data_phase(0, 1'b1);
    chk("hz_released", rd_rdy, 1);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("hz_late_araddr", araddr, 32'h1C00_0084);
    chk("hz_late_arvalid", arvalid, 1);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5A5A_0002;
    #1;
    chk("hz_late_ret", ret_data, 32'h5A5A_0002);
    cyc();
    rvalid = 1'b0; rlast = 1'b0;

    // Reset during beat 2 of a line read, with a write stuck in AW.
    rd_req = 1'b1; rd_type = 3'd4; rd_addr = 32'h1C00_0040;
    wr_req = 1'b1; wr_type = 3'd4; wr_addr = 32'h1C00_0200; wr_data = '1;
    cyc();
    rd_req = 1'b0; wr_req = 1'b0;
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'hA0 + 32'(i); rlast = 1'b0;
      #1;
      chk("rst_seq_beat", ret_data, 32'hA0 + 32'(i));
      cyc();
    end
    rvalid = 1'b1; rdata = 32'hA2; resetn = 1'b0;
    #1;
    chk("rst_seq_beat2_valid", ret_valid, 1);
    cyc();
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_awvalid", awvalid, 0);
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_rready", rready, 0);
    chk("rst_mid_bready", bready, 0);
    chk("rst_mid_ret_valid", ret_valid, 0);
    chk("rst_mid_rd_rdy", rd_rdy, 1);
    chk("rst_mid_wr_rdy", wr_rdy, 1);
    resetn = 1'b1; rvalid = 1'b0;
    cyc();

    // Recovery after reset.
    do_read(vecs[4], 32'hA0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
